// File: rtl/serial_shifter_if.sv
// Request/response bundle for the multi-cycle shift unit.
// The master drives requests and consumes results; the slave is the shifter.
interface serial_shifter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic [1:0]       op;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             busy;

  modport master (
    output in_valid, din, shamt, op, flush, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, shamt, op, flush, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/serial_shifter.sv
// Sequential shift unit: sll/srl/sra/rotr, one bit position per clock.
// Valid/ready on both sides; busy lets the hazard unit stall the pipeline.
module serial_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_shifter_if.slave   bus
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_ROTR = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [SHW-1:0]   cnt;
  logic [1:0]       op_r;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // One-position step of the selected operation.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] o);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
      OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROTR: r = {d[0], d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Status flags are registered alongside the state so no input reaches an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      data        <= '0;
      cnt         <= '0;
      op_r        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data       <= bus.din;
            cnt        <= bus.shamt;
            op_r       <= bus.op;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.shamt != '0) begin
              state <= SHIFT;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data <= step(data, op_r);
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.dout      = data;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: vector table with a result scoreboard,
// plus hand sequences for reset, backpressure and flush.
module tb_serial_shifter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_shifter_if #(.WIDTH(32), .SHW(5)) bus ();

  serial_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] din;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flags(input string name, input logic [2:0] exp);
    check(name, 32'({bus.in_ready, bus.busy, bus.out_valid}), 32'(exp));
  endtask

  task automatic do_accept(input logic [31:0] d, input logic [4:0] n, input logic [1:0] o);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      tick();
      guard++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.din      = d;
    bus.shamt    = n;
    bus.op       = o;
    tick();
    bus.in_valid = 1'b0;
    bus.din      = $urandom;
    bus.shamt    = 5'($urandom);
    bus.op       = 2'($urandom);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic sb_compare(input string name);
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid never rose, got 0 expected 1", name);
      sb.delete();
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: result got %h expected none pending", name, bus.dout);
    end else begin
      check(name, bus.dout, sb.pop_front());
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] held;
    logic        seen;

    checks = 0;
    errors = 0;

    vecs[0]  = '{32'h0FF0F00F, 5'd4,  2'b00, 32'hFF0F00F0};
    vecs[1]  = '{32'h0FF0F00F, 5'd4,  2'b01, 32'h00FF0F00};
    vecs[2]  = '{32'h24345518, 5'd2,  2'b00, 32'h90D15460};
    vecs[3]  = '{32'h80000001, 5'd4,  2'b11, 32'hF8000000};
    vecs[4]  = '{32'h7FFFFFFF, 5'd31, 2'b11, 32'h00000000};
    vecs[5]  = '{32'h12345678, 5'd8,  2'b10, 32'h78123456};
    vecs[6]  = '{32'hDEADBEEF, 5'd0,  2'b00, 32'hDEADBEEF};
    vecs[7]  = '{32'h00000001, 5'd31, 2'b00, 32'h80000000};
    vecs[8]  = '{32'h80000001, 5'd1,  2'b10, 32'hC0000000};
    vecs[9]  = '{32'hF0000000, 5'd31, 2'b11, 32'hFFFFFFFF};
    vecs[10] = '{32'h80000000, 5'd31, 2'b01, 32'h00000001};
    vecs[11] = '{32'hCAFE0001, 5'd0,  2'b11, 32'hCAFE0001};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.shamt     = '0;
    bus.op        = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values.
    tick();
    flags("reset_flags", 3'b100);
    check("reset_dout", bus.dout, 32'h0);
    rst_n = 1'b1;
    tick();

    // Reset asserted in the middle of a shift clears outputs without a clock edge.
    do_accept(32'hA5A5A5A5, 5'd10, 2'b00);
    tick();
    tick();
    tick();
    flags("midshift_flags", 3'b010);
    #2 rst_n = 1'b0;
    #1;
    flags("async_reset_flags", 3'b100);
    check("async_reset_dout", bus.dout, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Table of operations, one result per request through the scoreboard.
    for (int i = 0; i < 12; i++) begin
      do_accept(vecs[i].din, vecs[i].shamt, vecs[i].op);
      sb.push_back(vecs[i].exp);
      check($sformatf("busy_v%0d", i), 32'(bus.busy), 32'd1);
      wait_valid(cyc);
      check($sformatf("latency_v%0d", i), 32'(cyc), 32'(vecs[i].shamt));
      sb_compare($sformatf("dout_v%0d", i));
      tick();
      flags($sformatf("idle_v%0d", i), 3'b100);
    end

    // Backpressure: DONE holds with a stable result and ignores new requests.
    bus.out_ready = 1'b0;
    do_accept(32'h12345678, 5'd8, 2'b10);
    sb.push_back(32'h78123456);
    wait_valid(cyc);
    held = bus.dout;
    sb_compare("bp_dout");
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.din      = $urandom;
      bus.shamt    = 5'd3;
      tick();
      flags($sformatf("bp_hold_flags_%0d", k), 3'b011);
      check($sformatf("bp_hold_dout_%0d", k), bus.dout, held);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    flags("bp_release", 3'b100);
    tick();
    flags("bp_no_stray_accept", 3'b100);

    // Flush during SHIFT: back to IDLE, no result ever appears.
    do_accept(32'hFFFF0000, 5'd10, 2'b01);
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    flags("flush_shift", 3'b100);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_shift_no_valid", 32'(seen), 32'd0);

    // Flush in DONE drops the pending result without a handshake.
    bus.out_ready = 1'b0;
    do_accept(32'h0000000F, 5'd2, 2'b00);
    wait_valid(cyc);
    check("flush_done_valid", 32'(bus.out_valid), 32'd1);
    check("flush_done_dout", bus.dout, 32'h0000003C);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    flags("flush_done", 3'b100);
    bus.out_ready = 1'b1;

    // Flush alongside a request in IDLE: request is not taken.
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.din      = 32'h11111111;
    bus.shamt    = 5'd3;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    flags("flush_idle_req", 3'b100);
    tick();
    flags("flush_idle_req_after", 3'b100);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
